dp_microseq: RTL and testbench

Microprogrammed sequencer for the register-file/ALU datapath. It replaces hard-wired control sequences with a loadable 24-bit micro-program. It drives the same datapath control bus (InsSel, InMuxAdd, RegAdd, OutMuxAdd, CUconst, WE) and supports conditional branching on the datapath CO/Z flags and counted loops. It sits between the top-level start/busy handshake and the datapath.

---
 rtl/dp_pkg.sv | 39 +++
 rtl/dp_microseq_if.sv | 32 +++
 rtl/dp_useq_mem.sv | 26 ++
 rtl/dp_microseq.sv | 144 ++++++++++++++
 tb/tb_dp_microseq.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared types and constants for the micro-sequencer
package dp_pkg;

   localparam int WORD_W  = 24;
   localparam int OP_W    = 3;
   localparam int INS_W   = 2;
   localparam int MUX_W   = 3;
   localparam int REG_W   = 4;
   localparam int OMUX_W  = 4;
   localparam int CONST_W = 8;

   typedef enum logic [OP_W-1:0] {
      OP_EXEC  = 3'b000,
      OP_JMP   = 3'b001,
      OP_BRZ   = 3'b010,
      OP_BRNZ  = 3'b011,
      OP_BRC   = 3'b100,
      OP_LOOP  = 3'b101,
      OP_LDCNT = 3'b110,
      OP_HALT  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2
   } state_e;

   // Field order from msb to lsb is the micro-word layout; branch target is cconst[AW-1:0].
   typedef struct packed {
      op_e                op;
      logic [INS_W-1:0]   ins_sel;
      logic [MUX_W-1:0]   in_mux;
      logic [REG_W-1:0]   reg_add;
      logic [OMUX_W-1:0]  out_mux;
      logic [CONST_W-1:0] cconst;
   } uword_t;

endpackage

// File: rtl/dp_microseq_if.sv
// rtl/dp_microseq_if.sv - handshake, program-load and datapath control bus
interface dp_microseq_if
   import dp_pkg::*;
#(
   parameter int AW = 5
);
   logic                 start;
   logic                 CO;
   logic                 Z;
   logic                 prog_we;
   logic [AW-1:0]        prog_addr;
   logic [WORD_W-1:0]    prog_data;
   logic                 busy;
   logic                 done;
   logic                 WE;
   logic [INS_W-1:0]     InsSel;
   logic [MUX_W-1:0]     InMuxAdd;
   logic [REG_W-1:0]     RegAdd;
   logic [OMUX_W-1:0]    OutMuxAdd;
   logic [CONST_W-1:0]   CUconst;
   logic [AW-1:0]        pc;

   modport master (
      input  start, CO, Z, prog_we, prog_addr, prog_data,
      output busy, done, WE, InsSel, InMuxAdd, RegAdd, OutMuxAdd, CUconst, pc
   );

   modport slave (
      output start, CO, Z, prog_we, prog_addr, prog_data,
      input  busy, done, WE, InsSel, InMuxAdd, RegAdd, OutMuxAdd, CUconst, pc
   );
endinterface

// File: rtl/dp_useq_mem.sv
// rtl/dp_useq_mem.sv - micro-program store, one write port and a registered read port
module dp_useq_mem
   import dp_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [WORD_W-1:0] rdata
);
   logic [WORD_W-1:0] mem_q [2**AW];
   logic [WORD_W-1:0] rdata_q;

   // Contents are deliberately not reset so a loaded program survives a sequencer reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/dp_microseq.sv
// rtl/dp_microseq.sv - microprogrammed sequencer driving the register-file/ALU control bus
module dp_microseq
   import dp_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic           clk,
   input  logic           reset,
   dp_microseq_if.master  bus
);
   state_e               state_q, state_d;
   logic [AW-1:0]        pc_q, pc_d;
   logic [CONST_W-1:0]   cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 we_q, we_d;
   logic [INS_W-1:0]     ins_sel_q, ins_sel_d;
   logic [MUX_W-1:0]     in_mux_q, in_mux_d;
   logic [REG_W-1:0]     reg_add_q, reg_add_d;
   logic [OMUX_W-1:0]    out_mux_q, out_mux_d;
   logic [CONST_W-1:0]   cconst_q, cconst_d;

   logic [WORD_W-1:0]    rdata;
   uword_t               iw;
   logic [AW-1:0]        tgt;
   logic [AW-1:0]        pc_inc;

   // The store is read every cycle at pc; the word fetched in FETCH is decoded in EXEC.
   dp_useq_mem #(.AW(AW)) u_mem (
      .clk   (clk),
      .we    (bus.prog_we && (state_q == ST_IDLE)),
      .waddr (bus.prog_addr),
      .wdata (bus.prog_data),
      .raddr (pc_q),
      .rdata (rdata)
   );

   assign iw     = uword_t'(rdata);
   assign tgt    = iw.cconst[AW-1:0];
   assign pc_inc = pc_q + AW'(1);

   // Next-state and next-output decode; WE and done are single-cycle, fields hold between EXECs.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      we_d      = 1'b0;
      ins_sel_d = ins_sel_q;
      in_mux_d  = in_mux_q;
      reg_add_d = reg_add_q;
      out_mux_d = out_mux_q;
      cconst_d  = cconst_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_FETCH;
               pc_d    = '0;
               busy_d  = 1'b1;
            end
         end
         ST_FETCH: begin
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            pc_d    = pc_inc;
            case (iw.op)
               OP_EXEC: begin
                  we_d      = 1'b1;
                  ins_sel_d = iw.ins_sel;
                  in_mux_d  = iw.in_mux;
                  reg_add_d = iw.reg_add;
                  out_mux_d = iw.out_mux;
                  cconst_d  = iw.cconst;
               end
               OP_JMP:  pc_d = tgt;
               OP_BRZ:  if (bus.Z)  pc_d = tgt;
               OP_BRNZ: if (!bus.Z) pc_d = tgt;
               OP_BRC:  if (bus.CO) pc_d = tgt;
               OP_LOOP: begin
                  // An exhausted counter falls through and stays at zero.
                  if (cnt_q != '0) begin
                     cnt_d = cnt_q - CONST_W'(1);
                     pc_d  = tgt;
                  end
               end
               OP_LDCNT: cnt_d = iw.cconst;
               OP_HALT: begin
                  state_d = ST_IDLE;
                  pc_d    = pc_q;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
               default: state_d = ST_IDLE;
            endcase
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // All sequencer state and outputs; reset discards any in-flight instruction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         we_q      <= 1'b0;
         ins_sel_q <= '0;
         in_mux_q  <= '0;
         reg_add_q <= '0;
         out_mux_q <= '0;
         cconst_q  <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         we_q      <= we_d;
         ins_sel_q <= ins_sel_d;
         in_mux_q  <= in_mux_d;
         reg_add_q <= reg_add_d;
         out_mux_q <= out_mux_d;
         cconst_q  <= cconst_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.WE        = we_q;
   assign bus.InsSel    = ins_sel_q;
   assign bus.InMuxAdd  = in_mux_q;
   assign bus.RegAdd    = reg_add_q;
   assign bus.OutMuxAdd = out_mux_q;
   assign bus.CUconst   = cconst_q;
   assign bus.pc        = pc_q;
endmodule

// File: tb/tb_dp_microseq.sv
// tb/tb_dp_microseq.sv - scoreboard bench for dp_microseq against an instruction-level model
module tb_dp_microseq;
   import dp_pkg::*;

   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;

   dp_microseq_if #(.AW(AW)) bus();

   dp_microseq #(.AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passes = 0;
   int we_seen = 0;

   typedef struct {
      int          cyc;
      logic [20:0] f;
   } wr_t;

   wr_t  wq[$];
   int   dq[$];
   int   pcq[$];

   logic [23:0] img [DEPTH];
   bit   m_z, m_co;
   int   m_cnt;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [23:0] mk(input int op, input int ins, input int mux,
                                      input int rg, input int om, input int c);
      return {op[2:0], ins[1:0], mux[2:0], rg[3:0], om[3:0], c[7:0]};
   endfunction

   // Instruction-level reference: walks the program with plain arithmetic, 2 cycles per instruction.
   task automatic model(input bit push, input int c0, output bit ok);
      int pc = 0;
      int cnt = m_cnt;
      logic [23:0] w;
      int op, tgt;
      ok = 1'b0;
      for (int k = 0; k < 120; k++) begin
         w   = img[pc];
         op  = int'(w[23:21]);
         tgt = int'(w[4:0]);
         if (push) begin
            pcq.push_back(pc);
            pcq.push_back(pc);
         end
         if (op == 7) begin
            if (push) begin
               dq.push_back(c0 + 2 * k + 3);
               m_cnt = cnt;
            end
            ok = 1'b1;
            break;
         end
         case (op)
            0: begin
               if (push) wq.push_back('{c0 + 2 * k + 3, w[20:0]});
               pc = (pc + 1) % DEPTH;
            end
            1: pc = tgt;
            2: pc = m_z  ? tgt : (pc + 1) % DEPTH;
            3: pc = !m_z ? tgt : (pc + 1) % DEPTH;
            4: pc = m_co ? tgt : (pc + 1) % DEPTH;
            5: begin
               if (cnt > 0) begin
                  cnt--;
                  pc = tgt;
               end else pc = (pc + 1) % DEPTH;
            end
            default: begin
               cnt = int'(w[7:0]);
               pc  = (pc + 1) % DEPTH;
            end
         endcase
      end
   endtask

   // Monitor: whenever the DUT presents busy/WE/done, pop and compare the expected item.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.busy) begin
            if (pcq.size() == 0) chk("busy_unexpected", bus.busy, 0);
            else chk("pc", bus.pc, pcq.pop_front());
         end
         if (bus.WE) begin
            we_seen++;
            if (wq.size() == 0) chk("we_unexpected", bus.WE, 0);
            else begin
               chk("we_fields", {bus.InsSel, bus.InMuxAdd, bus.RegAdd, bus.OutMuxAdd, bus.CUconst}, wq[0].f);
               chk("we_cycle", cyc, wq[0].cyc);
               void'(wq.pop_front());
            end
         end
         if (bus.done) begin
            if (dq.size() == 0) chk("done_unexpected", bus.done, 0);
            else chk("done_cycle", cyc, dq.pop_front());
         end
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_done"}, bus.done, 0);
      chk({tag, "_we"}, bus.WE, 0);
      chk({tag, "_inssel"}, bus.InsSel, 0);
      chk({tag, "_inmux"}, bus.InMuxAdd, 0);
      chk({tag, "_regadd"}, bus.RegAdd, 0);
      chk({tag, "_outmux"}, bus.OutMuxAdd, 0);
      chk({tag, "_cuconst"}, bus.CUconst, 0);
      chk({tag, "_pc"}, bus.pc, 0);
      chk({tag, "_cnt"}, dut.cnt_q, 0);
   endtask

   task automatic load();
      for (int a = 0; a < DEPTH; a++) begin
         @(negedge clk);
         bus.prog_we   = 1'b1;
         bus.prog_addr = a[AW-1:0];
         bus.prog_data = img[a];
      end
      @(negedge clk);
      bus.prog_we = 1'b0;
   endtask

   // noise: 0 quiet, 1 random start/prog_we while busy, 2 start and prog_we to address 1 every busy cycle
   task automatic run(input bit z, input bit co, input int noise, input bit abort);
      bit ok;
      bit seen;
      int c0;
      @(negedge clk);
      bus.Z = z;
      bus.CO = co;
      m_z = z;
      m_co = co;
      c0 = cyc;
      model(1'b1, c0, ok);
      bus.start = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         bus.start   = 1'b0;
         bus.prog_we = 1'b0;
         if (abort && bus.WE) begin
            reset = 1'b1;
            #1;
            chk_reset_vals("midrun");
            wq.delete();
            pcq.delete();
            dq.delete();
            m_cnt = 0;
            @(negedge clk);
            reset = 1'b0;
            return;
         end
         if (bus.done) seen = 1'b1;
         else if (bus.busy && noise != 0) begin
            bus.start     = (noise == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.prog_we   = (noise == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.prog_addr = (noise == 2) ? AW'(1) : AW'($urandom_range(0, DEPTH - 1));
            bus.prog_data = 24'($urandom);
         end
      end
      #1;
      chk("done_seen", seen, 1);
      chk("queues_drained", wq.size() + pcq.size() + dq.size(), 0);
   endtask

   task automatic fill_halt();
      for (int a = 0; a < DEPTH; a++) img[a] = mk(7, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      bit ok;
      int we0;
      bus.start = 1'b0;
      bus.CO = 1'b0;
      bus.Z = 1'b0;
      bus.prog_we = 1'b0;
      bus.prog_addr = '0;
      bus.prog_data = '0;
      m_cnt = 0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      reset = 1'b0;

      // pc wraps from 31 to 0: straight EXEC run from 4 to 31, then LOOP at 0 exits to HALT.
      img[0] = mk(5, 0, 0, 0, 0, 2);
      img[1] = mk(1, 0, 0, 0, 0, 3);
      img[2] = mk(7, 0, 0, 0, 0, 0);
      img[3] = mk(6, 0, 0, 0, 0, 1);
      for (int a = 4; a < DEPTH; a++) img[a] = mk(0, a % 4, a % 8, a % 16, (a + 3) % 16, a);
      load();
      run(0, 0, 0, 0);

      // Two-instruction program: done 5 cycles after start.
      fill_halt();
      img[0] = mk(0, 2, 3, 2, 0, 0);
      load();
      run(0, 0, 0, 0);
      chk("busy_after_halt", bus.busy, 0);

      // Counted loop: 4 writes, counter ends at 0.
      fill_halt();
      img[0] = mk(6, 0, 0, 0, 0, 3);
      img[1] = mk(0, 1, 1, 1, 0, 8'h11);
      img[2] = mk(5, 0, 0, 0, 0, 1);
      load();
      we0 = we_seen;
      run(0, 0, 0, 0);
      chk("loop_we_pulses", we_seen - we0, 4);
      chk("loop_cnt_end", dut.cnt_q, 0);

      // Conditional branches at pc=2 to target 5, taken and not taken.
      for (int b = 0; b < 4; b++) begin
         fill_halt();
         img[0] = mk(0, 1, 2, 3, 4, 8'h21);
         img[1] = mk(0, 2, 3, 4, 5, 8'h22);
         img[2] = mk((b < 2) ? 2 : 4, 0, 0, 0, 0, 5);
         img[3] = mk(0, 3, 4, 5, 6, 8'h23);
         img[5] = mk(0, 0, 5, 6, 7, 8'h25);
         load();
         run((b == 0), (b == 2), 0, 0);
      end

      // Reset during the WE cycle, then a clean re-run from pc=0.
      fill_halt();
      img[0] = mk(6, 0, 0, 0, 0, 2);
      img[1] = mk(0, 3, 7, 9, 1, 8'hA5);
      img[2] = mk(5, 0, 0, 0, 0, 1);
      load();
      run(0, 0, 0, 1);
      run(0, 0, 0, 0);

      // Writes and start while busy are ignored; the re-run proves address 1 is intact.
      fill_halt();
      img[0] = mk(0, 1, 1, 1, 1, 8'h01);
      img[1] = mk(0, 2, 6, 12, 9, 8'h5A);
      load();
      run(0, 0, 2, 0);
      run(0, 0, 0, 0);

      // Random programs that terminate within the model's instruction bound.
      for (int r = 0; r < 25; r++) begin
         m_z = 1'($urandom_range(0, 1));
         m_co = 1'($urandom_range(0, 1));
         ok = 1'b0;
         while (!ok) begin
            for (int a = 0; a < DEPTH; a++) begin
               int sel;
               sel = int'($urandom_range(0, 15));
               if (sel <= 6)       img[a] = mk(0, $urandom_range(0, 3), $urandom_range(0, 7),
                                               $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
               else if (sel <= 11) img[a] = mk(sel - 6, 0, 0, 0, 0, $urandom_range(0, 255));
               else if (sel == 12) img[a] = mk(6, 0, 0, 0, 0, $urandom_range(0, 3));
               else                img[a] = mk(7, 0, 0, 0, 0, 0);
            end
            model(1'b0, 0, ok);
         end
         load();
         run(m_z, m_co, 1, 0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
